// File: rtl/trap_pkg.sv
// Shared encodings for the machine-mode trap sequencer: FSM states,
// PC-select codes and mcause exception/interrupt codes.
package trap_pkg;

    typedef enum logic [1:0] {
        ST_RESET       = 2'd0,
        ST_OPERATING   = 2'd1,
        ST_TRAP_TAKEN  = 2'd2,
        ST_TRAP_RETURN = 2'd3
    } state_t;

    localparam logic [1:0] PC_SEQ   = 2'b00;
    localparam logic [1:0] PC_MTVEC = 2'b01;
    localparam logic [1:0] PC_MEPC  = 2'b10;

    localparam int EXC_INSTR_MISALIGNED = 0;
    localparam int EXC_ILLEGAL          = 2;
    localparam int EXC_EBREAK           = 3;
    localparam int EXC_LOAD_MISALIGNED  = 4;
    localparam int EXC_STORE_MISALIGNED = 6;
    localparam int EXC_ECALL            = 11;

    localparam int INT_SOFTWARE = 3;
    localparam int INT_TIMER    = 7;
    localparam int INT_EXTERNAL = 11;

endpackage

// File: rtl/trap_cause_prio.sv
// Combinational priority encoder: picks the winning exception, or failing
// that the highest-priority enabled interrupt, and reports its mcause code.
module trap_cause_prio
    import trap_pkg::*;
#(
    parameter int CAUSE_W = 4
) (
    input  logic               mie_in,
    input  logic               meie_in,
    input  logic               mtie_in,
    input  logic               msie_in,
    input  logic               meip_in,
    input  logic               mtip_in,
    input  logic               msip_in,
    input  logic               instr_misaligned_in,
    input  logic               illegal_instr_in,
    input  logic               ebreak_in,
    input  logic               ecall_in,
    input  logic               load_misaligned_in,
    input  logic               store_misaligned_in,
    output logic               valid_out,
    output logic               i_or_e_out,
    output logic [CAUSE_W-1:0] cause_out
);

    // NOTE: every output gets a default before the if-chain so no path
    // through the block leaves a signal unassigned and infers a latch.
    always_comb begin
        valid_out  = 1'b1;
        i_or_e_out = 1'b0;
        cause_out  = '0;
        if (instr_misaligned_in)      cause_out = CAUSE_W'(EXC_INSTR_MISALIGNED);
        else if (illegal_instr_in)    cause_out = CAUSE_W'(EXC_ILLEGAL);
        else if (ebreak_in)           cause_out = CAUSE_W'(EXC_EBREAK);
        else if (ecall_in)            cause_out = CAUSE_W'(EXC_ECALL);
        else if (load_misaligned_in)  cause_out = CAUSE_W'(EXC_LOAD_MISALIGNED);
        else if (store_misaligned_in) cause_out = CAUSE_W'(EXC_STORE_MISALIGNED);
        else if (mie_in) begin
            // Interrupts only reach here when no exception is pending.
            i_or_e_out = 1'b1;
            if (meip_in && meie_in)      cause_out = CAUSE_W'(INT_EXTERNAL);
            else if (msip_in && msie_in) cause_out = CAUSE_W'(INT_SOFTWARE);
            else if (mtip_in && mtie_in) cause_out = CAUSE_W'(INT_TIMER);
            else                         valid_out = 1'b0;
        end else begin
            valid_out = 1'b0;
        end
    end

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: drives the mstatus MIE/MPIE handshake,
// mcause/mepc write strobes and the PC-select mux on trap entry and mret.
module trap_controller
    import trap_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int CAUSE_W = 4
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [XLEN-1:0]    pc_in,
    input  logic               mie_in,
    input  logic               meie_in,
    input  logic               mtie_in,
    input  logic               msie_in,
    input  logic               meip_in,
    input  logic               mtip_in,
    input  logic               msip_in,
    input  logic               instr_misaligned_in,
    input  logic               illegal_instr_in,
    input  logic               ebreak_in,
    input  logic               ecall_in,
    input  logic               load_misaligned_in,
    input  logic               store_misaligned_in,
    input  logic               mret_in,
    output logic               mie_clear_out,
    output logic               mie_set_out,
    output logic               set_cause_out,
    output logic               i_or_e_out,
    output logic [CAUSE_W-1:0] cause_out,
    output logic               set_epc_out,
    output logic [XLEN-1:0]    epc_out,
    output logic [1:0]         pc_src_out,
    output logic               flush_out,
    output logic               trap_taken_out
);

    state_t               state;
    state_t               next_state;
    logic                 prio_valid;
    logic                 prio_i_or_e;
    logic [CAUSE_W-1:0]   prio_cause;
    logic                 take_trap;
    logic [CAUSE_W-1:0]   cause_q;
    logic                 i_or_e_q;
    logic [XLEN-1:0]      epc_q;

    trap_cause_prio #(.CAUSE_W(CAUSE_W)) u_prio (
        .mie_in              (mie_in),
        .meie_in             (meie_in),
        .mtie_in             (mtie_in),
        .msie_in             (msie_in),
        .meip_in             (meip_in),
        .mtip_in             (mtip_in),
        .msip_in             (msip_in),
        .instr_misaligned_in (instr_misaligned_in),
        .illegal_instr_in    (illegal_instr_in),
        .ebreak_in           (ebreak_in),
        .ecall_in            (ecall_in),
        .load_misaligned_in  (load_misaligned_in),
        .store_misaligned_in (store_misaligned_in),
        .valid_out           (prio_valid),
        .i_or_e_out          (prio_i_or_e),
        .cause_out           (prio_cause)
    );

    // mret outranks interrupts but not exceptions.
    assign take_trap = prio_valid && !(prio_i_or_e && mret_in);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= ST_RESET;
            cause_q  <= '0;
            i_or_e_q <= 1'b0;
            epc_q    <= '0;
        end else begin
            state <= next_state;
            if (state == ST_OPERATING && take_trap) begin
                cause_q  <= prio_cause;
                i_or_e_q <= prio_i_or_e;
                epc_q    <= pc_in;
            end
        end
    end

    always_comb begin
        next_state     = state;
        mie_clear_out  = 1'b0;
        mie_set_out    = 1'b0;
        set_cause_out  = 1'b0;
        set_epc_out    = 1'b0;
        trap_taken_out = 1'b0;
        flush_out      = 1'b0;
        pc_src_out     = PC_SEQ;
        case (state)
            ST_RESET: next_state = ST_OPERATING;
            ST_OPERATING: begin
                if (take_trap)    next_state = ST_TRAP_TAKEN;
                else if (mret_in) next_state = ST_TRAP_RETURN;
            end
            ST_TRAP_TAKEN: begin
                mie_clear_out  = 1'b1;
                set_cause_out  = 1'b1;
                set_epc_out    = 1'b1;
                trap_taken_out = 1'b1;
                flush_out      = 1'b1;
                pc_src_out     = PC_MTVEC;
                next_state     = ST_OPERATING;
            end
            ST_TRAP_RETURN: begin
                mie_set_out = 1'b1;
                flush_out   = 1'b1;
                pc_src_out  = PC_MEPC;
                next_state  = ST_OPERATING;
            end
            default: next_state = ST_RESET;
        endcase
    end

    assign cause_out  = cause_q;
    assign i_or_e_out = i_or_e_q;
    assign epc_out    = epc_q;

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: directed scenarios followed by
// randomized traffic, all compared against a cycle-level reference model.
`timescale 1ns/1ps
module tb_trap_controller;

    localparam int XLEN    = 32;
    localparam int CAUSE_W = 4;

    // Model phases: what the DUT shows during the current cycle.
    localparam int K_IDLE_RST = 0;  // cycle right after reset, inputs ignored
    localparam int K_OPER     = 1;  // accepting events
    localparam int K_TRAP     = 2;  // trap-entry cycle
    localparam int K_RET      = 3;  // mret cycle

    logic               clk_in = 1'b0;
    logic               rst_in;
    logic [XLEN-1:0]    pc_in;
    logic               mie_in, meie_in, mtie_in, msie_in;
    logic               meip_in, mtip_in, msip_in;
    logic               instr_misaligned_in, illegal_instr_in, ebreak_in;
    logic               ecall_in, load_misaligned_in, store_misaligned_in;
    logic               mret_in;
    logic               mie_clear_out, mie_set_out, set_cause_out, i_or_e_out;
    logic [CAUSE_W-1:0] cause_out;
    logic               set_epc_out;
    logic [XLEN-1:0]    epc_out;
    logic [1:0]         pc_src_out;
    logic               flush_out, trap_taken_out;

    int checks = 0;
    int passed = 0;

    int              m_kind = K_IDLE_RST;
    int              m_cause = 0;
    bit              m_ie = 1'b0;
    logic [XLEN-1:0] m_epc = '0;

    trap_controller #(.XLEN(XLEN), .CAUSE_W(CAUSE_W)) dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .pc_in               (pc_in),
        .mie_in              (mie_in),
        .meie_in             (meie_in),
        .mtie_in             (mtie_in),
        .msie_in             (msie_in),
        .meip_in             (meip_in),
        .mtip_in             (mtip_in),
        .msip_in             (msip_in),
        .instr_misaligned_in (instr_misaligned_in),
        .illegal_instr_in    (illegal_instr_in),
        .ebreak_in           (ebreak_in),
        .ecall_in            (ecall_in),
        .load_misaligned_in  (load_misaligned_in),
        .store_misaligned_in (store_misaligned_in),
        .mret_in             (mret_in),
        .mie_clear_out       (mie_clear_out),
        .mie_set_out         (mie_set_out),
        .set_cause_out       (set_cause_out),
        .i_or_e_out          (i_or_e_out),
        .cause_out           (cause_out),
        .set_epc_out         (set_epc_out),
        .epc_out             (epc_out),
        .pc_src_out          (pc_src_out),
        .flush_out           (flush_out),
        .trap_taken_out      (trap_taken_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_inputs();
        {mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in} = '0;
        {instr_misaligned_in, illegal_instr_in, ebreak_in} = '0;
        {ecall_in, load_misaligned_in, store_misaligned_in, mret_in} = '0;
        pc_in = '0;
    endtask

    // Advances one clock, updates the reference model from the inputs that
    // were applied before the edge, then compares every DUT output.
    task automatic cycle();
        int              exc_code [6] = '{0, 2, 3, 11, 4, 6};
        int              int_code [3] = '{11, 3, 7};
        bit              exc [6];
        bit              irq [3];
        int              nk = K_OPER;
        int              nc = m_cause;
        bit              ni = m_ie;
        logic [XLEN-1:0] ne = m_epc;
        bit              found = 1'b0;
        logic [7:0]      exp_strobes;

        exc = '{instr_misaligned_in, illegal_instr_in, ebreak_in,
                ecall_in, load_misaligned_in, store_misaligned_in};
        irq = '{meip_in && meie_in, msip_in && msie_in, mtip_in && mtie_in};

        if (rst_in) begin
            nk = K_IDLE_RST; nc = 0; ni = 1'b0; ne = '0;
        end else if (m_kind == K_OPER) begin
            for (int i = 0; i < 6; i++)
                if (!found && exc[i]) begin
                    found = 1'b1; nk = K_TRAP; nc = exc_code[i]; ni = 1'b0; ne = pc_in;
                end
            if (!found && mret_in) begin
                found = 1'b1; nk = K_RET;
            end
            for (int i = 0; i < 3; i++)
                if (!found && mie_in && irq[i]) begin
                    found = 1'b1; nk = K_TRAP; nc = int_code[i]; ni = 1'b1; ne = pc_in;
                end
        end

        @(posedge clk_in);
        #1;
        m_kind = nk; m_cause = nc; m_ie = ni; m_epc = ne;

        exp_strobes = {m_kind == K_TRAP, m_kind == K_RET, m_kind == K_TRAP,
                       m_kind == K_TRAP, m_kind == K_TRAP,
                       m_kind == K_TRAP || m_kind == K_RET,
                       (m_kind == K_RET) ? 2'b10 : (m_kind == K_TRAP) ? 2'b01 : 2'b00};
        check("strobes", {mie_clear_out, mie_set_out, set_cause_out, set_epc_out,
                          trap_taken_out, flush_out, pc_src_out}, exp_strobes);
        check("cause", cause_out, m_cause);
        check("i_or_e", i_or_e_out, m_ie);
        check("epc", epc_out, m_epc);
    endtask

    initial begin
        // Reset with every input high: outputs stay idle throughout.
        rst_in = 1'b1;
        {mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in} = '1;
        {instr_misaligned_in, illegal_instr_in, ebreak_in} = '1;
        {ecall_in, load_misaligned_in, store_misaligned_in, mret_in} = '1;
        pc_in = 32'hFFFF_FFFC;
        cycle();
        cycle();
        check("rst_pc_src", pc_src_out, 2'b00);
        check("rst_epc", epc_out, 0);

        // RESET cycle ignores the still-high inputs; OPERATING then takes cause 0.
        rst_in = 1'b0;
        cycle();
        check("rst_exit_idle", trap_taken_out, 1'b0);
        cycle();
        check("first_trap_cause", cause_out, 0);
        check("first_trap_epc", epc_out, 32'hFFFF_FFFC);

        clear_inputs();
        cycle();

        // Illegal beats ecall; single-cycle pulse.
        illegal_instr_in = 1'b1; ecall_in = 1'b1; pc_in = 32'h100;
        cycle();
        clear_inputs();
        check("ill_clear", mie_clear_out, 1'b1);
        check("ill_cause", cause_out, 2);
        check("ill_epc", epc_out, 32'h100);
        check("ill_pc_src", pc_src_out, 2'b01);
        cycle();
        check("ill_single_pulse", mie_clear_out, 1'b0);

        // External beats timer; then the same with MIE off takes nothing.
        mie_in = 1'b1; meie_in = 1'b1; mtie_in = 1'b1; meip_in = 1'b1; mtip_in = 1'b1;
        pc_in = 32'h200;
        cycle();
        check("irq_cause", cause_out, 11);
        check("irq_i_or_e", i_or_e_out, 1'b1);
        mie_in = 1'b0;
        cycle();
        cycle();
        check("irq_masked", trap_taken_out, 1'b0);

        // mret with timer pending and MIE low; MIE rises during TRAP_RETURN.
        mret_in = 1'b1;
        meip_in = 1'b0; meie_in = 1'b0;
        cycle();
        check("mret_set", mie_set_out, 1'b1);
        check("mret_pc_src", pc_src_out, 2'b10);
        mret_in = 1'b0; mie_in = 1'b1; pc_in = 32'h300;
        cycle();
        check("mret_then_oper", trap_taken_out, 1'b0);
        cycle();
        check("mret_then_timer", cause_out, 7);
        clear_inputs();
        cycle();

        // Exception beats mret.
        mret_in = 1'b1; store_misaligned_in = 1'b1; pc_in = 32'h400;
        cycle();
        clear_inputs();
        check("exc_over_mret_cause", cause_out, 6);
        check("exc_over_mret_set", mie_set_out, 1'b0);

        // Reset during TRAP_TAKEN drops the pulse and clears the latches.
        cycle();
        ecall_in = 1'b1; pc_in = 32'h500;
        cycle();
        check("pre_rst_trap", trap_taken_out, 1'b1);
        clear_inputs();
        rst_in = 1'b1;
        cycle();
        check("rst_in_trap_clear", mie_clear_out, 1'b0);
        check("rst_in_trap_cause", cause_out, 0);
        check("rst_in_trap_epc", epc_out, 0);
        rst_in = 1'b0;
        cycle();

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            rst_in              = ($urandom_range(0, 59) == 0);
            instr_misaligned_in = ($urandom_range(0, 15) == 0);
            illegal_instr_in    = ($urandom_range(0, 15) == 0);
            ebreak_in           = ($urandom_range(0, 15) == 0);
            ecall_in            = ($urandom_range(0, 15) == 0);
            load_misaligned_in  = ($urandom_range(0, 15) == 0);
            store_misaligned_in = ($urandom_range(0, 15) == 0);
            mret_in             = ($urandom_range(0, 7) == 0);
            mie_in              = 1'($urandom_range(0, 1));
            meie_in             = 1'($urandom_range(0, 1));
            mtie_in             = 1'($urandom_range(0, 1));
            msie_in             = 1'($urandom_range(0, 1));
            meip_in             = ($urandom_range(0, 2) == 0);
            mtip_in             = ($urandom_range(0, 2) == 0);
            msip_in             = ($urandom_range(0, 2) == 0);
            pc_in               = $urandom() & 32'hFFFF_FFFC;
            cycle();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Machine-mode trap sequencer; the producer side of the mstatus MIE/MPIE handshake.
- Watches exceptions, enabled interrupts and mret from the execute stage.
- On trap entry it pulses mie_clear_out, loads mcause/mepc and redirects fetch to the trap vector. On mret it pulses mie_set_out and redirects fetch to mepc.
- Sits between the CSR file (mstatus, mie, mip, mcause, mepc) and the PC-select mux.

Parameters:
- XLEN, 32, width of pc_in/epc_out.
- CAUSE_W, 4, width of cause_out.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  synchronous active-high reset
- pc_in  input  XLEN  PC of the instruction currently in execute
- mie_in  input  1  mstatus.MIE from the mstatus register
- meie_in, mtie_in, msie_in  input  1 each  mie enable bits
- meip_in, mtip_in, msip_in  input  1 each  pending external/timer/software interrupt
- instr_misaligned_in, illegal_instr_in, ebreak_in, ecall_in, load_misaligned_in, store_misaligned_in  input  1 each  exception flags for the execute instruction
- mret_in  input  1  execute instruction is mret
- mie_clear_out  output  1  one-cycle pulse to mstatus: MPIE<=MIE, MIE<=0
- mie_set_out  output  1  one-cycle pulse to mstatus: MIE<=MPIE, MPIE<=1
- set_cause_out  output  1  mcause write strobe
- i_or_e_out  output  1  mcause[31]: 1 = interrupt, 0 = exception
- cause_out  output  CAUSE_W  mcause exception code
- set_epc_out  output  1  mepc write strobe
- epc_out  output  XLEN  value for mepc
- pc_src_out  output  2  00 = sequential, 01 = mtvec, 10 = mepc
- flush_out  output  1  kill the instruction in execute and its CSR write
- trap_taken_out  output  1  high during the trap-entry cycle

Behaviour:
- Clock and reset: single clock clk_in; synchronous active-high reset rst_in.
- FSM states: RESET, OPERATING, TRAP_TAKEN, TRAP_RETURN.
- rst_in high at a clock edge:
  - state<=RESET; cause, i_or_e and epc registers <=0.
  - All outputs 0, pc_src_out=00. This holds in any state, including mid-TRAP_TAKEN, where the pending mie_clear/set_cause pulse is dropped.
- RESET: always goes to OPERATING on the next edge; outputs idle.
- OPERATING, decided each cycle in priority order:
  1. Any exception flag: exception code by priority instr_misaligned=0 > illegal=2 > ebreak=3 > ecall=11 > load_misaligned=4 > store_misaligned=6. Latch cause, i_or_e=0, epc<=pc_in; go to TRAP_TAKEN.
  2. Else mret_in: go to TRAP_RETURN.
  3. Else mie_in AND any (meip&meie | msip&msie | mtip&mtie): code by priority external=11 > software=3 > timer=7. i_or_e=1, epc<=pc_in; go to TRAP_TAKEN.
  4. Else stay in OPERATING; all strobes 0, pc_src_out=00.
- Decision outputs are registered: strobes appear exactly one cycle after the cycle in which the event was sampled.
- TRAP_TAKEN (exactly 1 cycle):
  - mie_clear_out=1, set_cause_out=1, set_epc_out=1, trap_taken_out=1, flush_out=1, pc_src_out=01.
  - cause_out, i_or_e_out and epc_out hold the latched values.
  - Goes to OPERATING unconditionally. Inputs in this cycle are ignored (not queued).
- TRAP_RETURN (exactly 1 cycle): mie_set_out=1, flush_out=1, pc_src_out=10; other strobes 0. Goes to OPERATING.
- mie_clear_out and mie_set_out are never high together. flush_out suppresses the CSR write of the flushed instruction, so the mstatus CSR-write path never competes with these pulses.
- Interrupt after mret: the interrupt is taken only once mie_in has risen, i.e. the earliest is the OPERATING cycle after TRAP_RETURN.
- Interrupts are level-sensitive; a source deasserted before sampling is not taken.
- cause_out, i_or_e_out and epc_out hold their last latched values outside TRAP_TAKEN. Observers must qualify them with the strobes.

Decomposition:
- Shared package trap_pkg:
  - FSM state encoding.
  - pc_src encodings (PC_SEQ, PC_MTVEC, PC_MEPC).
  - Exception/interrupt cause codes.
- One natural sub-module, trap_cause_prio: the combinational priority encoder producing {valid, i_or_e, cause} from the flags and enables. The FSM and registers stay in the top.

Test Plan:
- Reset: rst_in high 2 cycles with all inputs high -> all outputs 0 and pc_src_out=00 during reset; RESET for one cycle, then OPERATING.
- Illegal+ecall: illegal_instr_in=1, ecall_in=1, pc_in=0x100 at cycle N -> cycle N+1: mie_clear_out=1, cause_out=2, i_or_e_out=0, epc_out=0x100, pc_src_out=01, flush_out=1; single pulse.
- Interrupt priority: mie_in=1, meie=mtie=1, meip=mtip=1 -> cause_out=11, i_or_e_out=1. Repeat with mie_in=0 -> no trap.
- mret then interrupt: mret_in=1 with mtip=mtie=1, mie_in=0 -> TRAP_RETURN (mie_set_out=1, pc_src_out=10). mie_in then rises -> next cycle TRAP_TAKEN with cause 7.
- Exception beats mret: mret_in=1 and store_misaligned_in=1 -> TRAP_TAKEN with cause 6; mie_set_out stays 0.
- Reset in TRAP_TAKEN: rst_in asserted during the TRAP_TAKEN cycle -> next cycle all strobes 0, cause_out=0, epc_out=0, state RESET.
